// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one uart_tx serializer among
// NUM_REQ byte streams, optionally prefixing each packet with a source header.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int HDR_EN  = 1,
  parameter int MAX_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [3:0]           grant_id,
  output logic                 pkt_done,
  output logic                 pkt_trunc
);

  typedef enum logic [1:0] {IDLE, LOAD, ACK, DRAIN} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_ptr;
  logic [3:0]  r_gid;
  logic        r_gv;
  logic        r_hdr;
  logic        r_last;
  logic [7:0]  r_txd;
  logic        r_start;
  logic        r_done;
  logic        r_trunc;

  logic [15:0] w_vld16;
  logic [15:0] w_last16;
  logic        w_found;
  logic [3:0]  w_sel;
  logic [4:0]  w_sum;
  logic [7:0]  w_byte;
  logic [3:0]  w_next;

  // Padding to 16 bits lets every lookup use a plain 4-bit index.
  assign w_vld16  = 16'(req_valid);
  assign w_last16 = 16'(req_last);
  assign w_next   = (r_gid == 4'(NUM_REQ - 1)) ? 4'd0 : r_gid + 4'd1;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + 5'(k);
      if (w_sum >= 5'(NUM_REQ)) w_sum = w_sum - 5'(NUM_REQ);
      if (!w_found && w_vld16[w_sum[3:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[3:0];
      end
    end
  end

  always_comb begin
    w_byte    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gid == 4'(i)) w_byte = req_data[8*i +: 8];
      req_ready[i] = (r_state == LOAD) && (r_gid == 4'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_gv    <= 1'b0;
      r_hdr   <= 1'b0;
      r_last  <= 1'b0;
      r_txd   <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_trunc <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!tx_busy && w_found) begin
            r_gid <= w_sel;
            r_gv  <= 1'b1;
            r_cnt <= '0;
            if (HDR_EN != 0) begin
              r_txd   <= 8'hA0 | {4'h0, w_sel};
              r_start <= 1'b1;
              r_hdr   <= 1'b1;
              r_state <= ACK;
            end else begin
              r_hdr   <= 1'b0;
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_vld16[r_gid]) begin
            r_txd   <= w_byte;
            r_start <= 1'b1;
            r_last  <= w_last16[r_gid];
            r_cnt   <= r_cnt + 16'd1;
            r_hdr   <= 1'b0;
            r_state <= ACK;
          end
        end
        ACK: begin
          if (tx_busy) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!tx_busy) begin
            if (r_hdr) begin
              r_state <= LOAD;
            end else if (r_last || (r_cnt == 16'(MAX_LEN))) begin
              // A truncated packet's tail re-arbitrates later as a fresh packet.
              r_done  <= r_last;
              r_trunc <= !r_last;
              r_gv    <= 1'b0;
              r_ptr   <= w_next;
              r_state <= IDLE;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_data     = r_txd;
  assign tx_start    = r_start;
  assign grant_valid = r_gv;
  assign grant_id    = r_gid;
  assign pkt_done    = r_done;
  assign pkt_trunc   = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a uart_tx busy model and a
// packet-level round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int ML = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic [7:0]    tx_data;
  logic          tx_start, tx_busy, grant_valid, pkt_done, pkt_trunc;
  logic [3:0]    grant_id;
  logic          m_busy = 1'b0;
  logic          ext_busy = 1'b0;

  assign tx_busy = m_busy | ext_busy;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .HDR_EN(1), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .grant_valid(grant_valid),
    .grant_id(grant_id), .pkt_done(pkt_done), .pkt_trunc(pkt_trunc));

  int checks = 0;
  int failures = 0;
  int mon_err = 0;
  logic [8:0] dq[NR][$];
  logic [8:0] mq[NR][$];
  int gap_cfg[NR];
  int gcnt[NR];
  logic [7:0] got_b[$];
  logic [7:0] exp_b[$];
  logic [4:0] got_e[$];
  logic [4:0] exp_e[$];
  int mptr = 0;
  logic m_pend = 1'b0;

  // Requester driver: pops a byte when it was accepted, then presents the next.
  initial begin : driver
    logic [NR-1:0] took;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < NR; i++) begin gap_cfg[i] = 0; gcnt[i] = 0; end
    forever begin
      @(posedge clk);
      took = req_valid & req_ready & {NR{~rst}};
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (took[i]) begin
          gcnt[i] = dq[i][0][8] ? 0 : gap_cfg[i];
          void'(dq[i].pop_front());
        end else if (gcnt[i] > 0) begin
          gcnt[i]--;
        end
        if (gcnt[i] == 0 && dq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = dq[i][0][7:0];
          req_last[i] = dq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // uart_tx model plus protocol watch on every cycle.
  initial begin : monitor
    int since;
    int m_cnt;
    logic prev_start;
    since = 100; m_cnt = 0; prev_start = 1'b0;
    forever begin
      @(posedge clk); #1;
      since++;
      if (tx_start) begin
        if (tx_busy) mon_err++;
        if (since < 2) mon_err++;
        if (prev_start) mon_err++;
        got_b.push_back(tx_data);
      end
      prev_start = tx_start;
      if ($countones(req_ready) > 1) mon_err++;
      if (req_ready != '0 && !grant_valid) mon_err++;
      if (pkt_done && pkt_trunc) mon_err++;
      if (pkt_done) got_e.push_back({1'b0, grant_id});
      if (pkt_trunc) got_e.push_back({1'b1, grant_id});
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          if (grant_valid) since = 0;
        end
      end
      if (m_pend) begin
        m_busy = 1'b1;
        m_cnt = $urandom_range(2, 6);
        m_pend = 1'b0;
      end
      if (tx_start) m_pend = 1'b1;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic push_byte(input int id, input logic [7:0] b, input logic last);
    dq[id].push_back({last, b});
    mq[id].push_back({last, b});
  endtask

  task automatic push_pkt(input int id, input int len, input int gap, input logic [7:0] base, input bit rnd);
    gap_cfg[id] = gap;
    for (int k = 0; k < len; k++)
      push_byte(id, rnd ? 8'($urandom) : base + 8'(k), k == len - 1);
  endtask

  // Reference: whole packets granted in round-robin order from the pointer.
  task automatic model_run();
    int id, n;
    logic [8:0] e;
    bit any;
    forever begin
      any = 1'b0; id = 0;
      for (int k = 0; k < NR; k++)
        if (!any && mq[(mptr + k) % NR].size() > 0) begin any = 1'b1; id = (mptr + k) % NR; end
      if (!any) break;
      exp_b.push_back(8'hA0 | 8'(id));
      n = 0;
      forever begin
        e = mq[id].pop_front();
        exp_b.push_back(e[7:0]);
        n++;
        if (e[8]) begin exp_e.push_back({1'b0, 4'(id)}); break; end
        if (n == ML) begin exp_e.push_back({1'b1, 4'(id)}); break; end
      end
      mptr = (id + 1) % NR;
    end
  endtask

  function automatic bit pending();
    bit p = m_pend | tx_busy | grant_valid;
    for (int i = 0; i < NR; i++) if (dq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #3;
      if (!pending()) begin ok = 1'b1; break; end
    end
  endtask

  task automatic clear_logs();
    got_b.delete(); exp_b.delete(); got_e.delete(); exp_e.delete();
  endtask

  task automatic apply_rst();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; mptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset tx_data got=%h exp=00", tx_data); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset grant_valid got=%b exp=0", grant_valid); end
    checks++; if (grant_id !== 4'h0) begin failures++; $display("FAIL reset grant_id got=%h exp=0", grant_id); end
    checks++; if ({pkt_done, pkt_trunc} !== 2'b00) begin failures++; $display("FAIL reset pkt pulses got=%b exp=00", {pkt_done, pkt_trunc}); end
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset req_ready got=%b exp=0000", req_ready); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset idle grant_valid got=%b exp=0", grant_valid); end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    @(posedge clk); #1;
    push_byte(1, 8'h00, 1'b0);
    push_byte(1, 8'hFF, 1'b1);
    model_run();
    @(posedge clk); #1;
    checks++; if ({tx_start, tx_data} !== {1'b1, 8'hA1}) begin failures++; $display("FAIL single latency start/data got=%b/%h exp=1/a1", tx_start, tx_data); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single drain timeout got=busy exp=idle"); end
    checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL single byte count got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[k]) if (k < got_b.size()) begin checks++; if (got_b[k] !== exp_b[k]) begin failures++; $display("FAIL single byte[%0d] got=%h exp=%h", k, got_b[k], exp_b[k]); end end
    checks++; if (got_e.size() != exp_e.size()) begin failures++; $display("FAIL single event count got=%0d exp=%0d", got_e.size(), exp_e.size()); end
    foreach (exp_e[k]) if (k < got_e.size()) begin checks++; if (got_e[k] !== exp_e[k]) begin failures++; $display("FAIL single event[%0d] got=%h exp=%h", k, got_e[k], exp_e[k]); end end
    checks++; if ({grant_valid, grant_id} !== {1'b0, 4'd1}) begin failures++; $display("FAIL single post grant got=%b/%0d exp=0/1", grant_valid, grant_id); end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_rst();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int id = 0; id < NR; id++) push_byte(id, 8'h10 + 8'(id), 1'b1);
    model_run();
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr drain timeout got=busy exp=idle"); end
    checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL rr byte count got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[k]) if (k < got_b.size()) begin checks++; if (got_b[k] !== exp_b[k]) begin failures++; $display("FAIL rr byte[%0d] got=%h exp=%h", k, got_b[k], exp_b[k]); end end
    checks++; if (got_e.size() != exp_e.size()) begin failures++; $display("FAIL rr event count got=%0d exp=%0d", got_e.size(), exp_e.size()); end
    foreach (exp_e[k]) if (k < got_e.size()) begin checks++; if (got_e[k] !== exp_e[k]) begin failures++; $display("FAIL rr event[%0d] got=%h exp=%h", k, got_e[k], exp_e[k]); end end
  endtask

  task automatic test_trunc();
    bit ok;
    clear_logs();
    push_pkt(2, 5, 0, 8'h01, 1'b0);
    model_run();
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL trunc drain timeout got=busy exp=idle"); end
    checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL trunc byte count got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[k]) if (k < got_b.size()) begin checks++; if (got_b[k] !== exp_b[k]) begin failures++; $display("FAIL trunc byte[%0d] got=%h exp=%h", k, got_b[k], exp_b[k]); end end
    checks++; if (got_e.size() != exp_e.size()) begin failures++; $display("FAIL trunc event count got=%0d exp=%0d", got_e.size(), exp_e.size()); end
    foreach (exp_e[k]) if (k < got_e.size()) begin checks++; if (got_e[k] !== exp_e[k]) begin failures++; $display("FAIL trunc event[%0d] got=%h exp=%h", k, got_e[k], exp_e[k]); end end
  endtask

  task automatic test_stall();
    bit seen0, idle;
    int bad;
    clear_logs();
    push_pkt(0, 3, 50, 8'h30, 1'b0);
    model_run();
    seen0 = 1'b0;
    for (int n = 0; n < 200 && !seen0; n++) begin
      @(posedge clk); #3;
      seen0 = grant_valid && (grant_id == 4'd0);
    end
    checks++; if (!seen0) begin failures++; $display("FAIL stall grant0 got=none exp=grant to 0"); end
    push_byte(3, 8'h77, 1'b1);
    model_run();
    bad = 0; idle = 1'b0;
    for (int n = 0; n < 5000 && !idle; n++) begin
      @(posedge clk); #3;
      if (req_ready[3] && dq[0].size() > 0) bad++;
      if (grant_valid && grant_id == 4'd3 && dq[0].size() > 0) bad++;
      idle = !pending();
    end
    checks++; if (!idle) begin failures++; $display("FAIL stall drain timeout got=busy exp=idle"); end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall preempt cycles got=%0d exp=0", bad); end
    checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL stall byte count got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[k]) if (k < got_b.size()) begin checks++; if (got_b[k] !== exp_b[k]) begin failures++; $display("FAIL stall byte[%0d] got=%h exp=%h", k, got_b[k], exp_b[k]); end end
    checks++; if (got_e.size() != exp_e.size()) begin failures++; $display("FAIL stall event count got=%0d exp=%0d", got_e.size(), exp_e.size()); end
    foreach (exp_e[k]) if (k < got_e.size()) begin checks++; if (got_e[k] !== exp_e[k]) begin failures++; $display("FAIL stall event[%0d] got=%h exp=%h", k, got_e[k], exp_e[k]); end end
  endtask

  task automatic test_busy_block();
    bit ok;
    int bad;
    clear_logs();
    @(negedge clk); ext_busy = 1'b1;
    push_byte(1, 8'h5A, 1'b1);
    model_run();
    bad = 0;
    repeat (20) begin @(posedge clk); #3; if (grant_valid || tx_start) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL busy_block grant cycles got=%0d exp=0", bad); end
    @(negedge clk); ext_busy = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL busy_block drain timeout got=busy exp=idle"); end
    checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL busy_block byte count got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[k]) if (k < got_b.size()) begin checks++; if (got_b[k] !== exp_b[k]) begin failures++; $display("FAIL busy_block byte[%0d] got=%h exp=%h", k, got_b[k], exp_b[k]); end end
    checks++; if (got_e.size() != exp_e.size()) begin failures++; $display("FAIL busy_block event count got=%0d exp=%0d", got_e.size(), exp_e.size()); end
  endtask

  task automatic test_rst_midframe();
    bit ok, hit;
    clear_logs();
    gap_cfg[1] = 0;
    dq[1].push_back({1'b0, 8'hC0});
    dq[1].push_back({1'b0, 8'hC1});
    dq[1].push_back({1'b1, 8'hC2});
    hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      @(posedge clk); #2;
      hit = (got_b.size() >= 3);
    end
    checks++; if (!hit) begin failures++; $display("FAIL rst_mid reach second byte got=%0d exp=3", got_b.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({tx_start, tx_data, grant_valid, grant_id, pkt_done, pkt_trunc} !== 16'h0) begin
      failures++; $display("FAIL rst_mid outputs got=%b/%h/%b/%h/%b/%b exp=all 0", tx_start, tx_data, grant_valid, grant_id, pkt_done, pkt_trunc); end
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL rst_mid req_ready got=%b exp=0000", req_ready); end
    clear_logs();
    @(negedge clk); @(negedge clk);
    rst = 1'b0; mptr = 2;
    exp_b.push_back(8'hA1); exp_b.push_back(8'hC2);
    exp_e.push_back({1'b0, 4'd1});
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_mid drain timeout got=busy exp=idle"); end
    checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL rst_mid byte count got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    foreach (exp_b[k]) if (k < got_b.size()) begin checks++; if (got_b[k] !== exp_b[k]) begin failures++; $display("FAIL rst_mid byte[%0d] got=%h exp=%h", k, got_b[k], exp_b[k]); end end
    checks++; if (got_e.size() != exp_e.size()) begin failures++; $display("FAIL rst_mid event count got=%0d exp=%0d", got_e.size(), exp_e.size()); end
    foreach (exp_e[k]) if (k < got_e.size()) begin checks++; if (got_e[k] !== exp_e[k]) begin failures++; $display("FAIL rst_mid event[%0d] got=%h exp=%h", k, got_e[k], exp_e[k]); end end
  endtask

  task automatic test_random();
    bit ok;
    int gap;
    for (int it = 0; it < 4; it++) begin
      clear_logs();
      for (int id = 0; id < NR; id++) begin
        gap = $urandom_range(0, 3);
        for (int p = $urandom_range(0, 2); p > 0; p--) push_pkt(id, $urandom_range(1, 5), gap, 8'h00, 1'b1);
      end
      model_run();
      wait_idle(ok);
      checks++; if (!ok) begin failures++; $display("FAIL random[%0d] drain timeout got=busy exp=idle", it); end
      checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL random[%0d] byte count got=%0d exp=%0d", it, got_b.size(), exp_b.size()); end
      foreach (exp_b[k]) if (k < got_b.size()) begin checks++; if (got_b[k] !== exp_b[k]) begin failures++; $display("FAIL random[%0d] byte[%0d] got=%h exp=%h", it, k, got_b[k], exp_b[k]); end end
      checks++; if (got_e.size() != exp_e.size()) begin failures++; $display("FAIL random[%0d] event count got=%0d exp=%0d", it, got_e.size(), exp_e.size()); end
      foreach (exp_e[k]) if (k < got_e.size()) begin checks++; if (got_e[k] !== exp_e[k]) begin failures++; $display("FAIL random[%0d] event[%0d] got=%h exp=%h", it, k, got_e[k], exp_e[k]); end end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_trunc();
    test_stall();
    test_busy_block();
    test_rst_midframe();
    test_random();
    checks++; if (mon_err != 0) begin failures++; $display("FAIL protocol watch violations got=%0d exp=0", mon_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters (e.g. per-path result streamers and status reporter of the QMC-LSM core). It grants one requester per packet, optionally prefixes a one-byte source header, then paces bytes into `uart_tx` through its `tx_start`/`tx_busy` handshake. It sits between the pricing datapath result ports and `uart_tx`.

## Interface
- `NUM_REQ`, 4, number of requesters; 2..16.
- `HDR_EN`, 1, 1 = emit header byte `8'hA0 | id` before each packet's payload.
- `MAX_LEN`, 256, maximum payload bytes per grant; 1..65535.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req_valid`  input  NUM_REQ  per-requester byte valid.
- `req_data`  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i].
- `req_last`  input  NUM_REQ  marks final payload byte of a packet.
- `req_ready`  output  NUM_REQ  byte accepted when valid && ready.
- `tx_data`  output  8  byte to `uart_tx`.
- `tx_start`  output  1  one-cycle launch pulse to `uart_tx`.
- `tx_busy`  input  1  from `uart_tx`; high while a frame is on the line.
- `grant_valid`  output  1  a packet is owned.
- `grant_id`  output  4  owning requester index.
- `pkt_done`  output  1  one-cycle pulse: packet ended normally.
- `pkt_trunc`  output  1  one-cycle pulse: packet cut at `MAX_LEN`.

## Operation
- States: IDLE, LOAD, ACK, DRAIN. Reset: state IDLE; `tx_start`, `tx_data`, `grant_valid`, `grant_id`, `pkt_done`, `pkt_trunc`, byte counter, round-robin pointer all 0.
- IDLE: when `tx_busy`=0 and any `req_valid`, select first asserted index searching from pointer upward, wrapping mod NUM_REQ. Register `grant_id`, set `grant_valid`, clear counter. If HDR_EN: same edge load `tx_data`=`8'hA0|id`, pulse `tx_start`, go ACK. Else go LOAD.
- LOAD: `req_ready[grant_id]` = 1 combinationally, all other ready bits 0. On valid: register `tx_data`, pulse `tx_start`, capture `req_last` into a last flag, increment counter, go ACK. No valid: hold LOAD (stall; line idles).
- ACK: wait for `tx_busy`=1, then DRAIN. `uart_tx` raises `tx_busy` the cycle after `tx_start`.
- DRAIN: wait for `tx_busy`=0. Then:
  - after header byte: go LOAD.
  - last flag set: pulse `pkt_done`, clear `grant_valid`, pointer <= (grant_id+1) mod NUM_REQ, go IDLE.
  - counter = MAX_LEN without last: pulse `pkt_trunc`, release as above; remaining bytes of that packet arbitrate later as a new packet.
  - otherwise: go LOAD.
- `req_ready` is 0 in every state except LOAD; never more than one bit set.
- Counter is 16 bits; never wraps because it is cleared each grant and compared to MAX_LEN ≤ 65535.
- `grant_id` holds last owner after release; only `grant_valid` indicates ownership.

## Timing
- `tx_start` asserted exactly one cycle per byte; `tx_data` stable from that cycle until next `tx_start`.
- Request-to-start latency (IDLE, `tx_busy`=0, HDR_EN=1): `req_valid` sampled edge N -> `tx_start` high after edge N. HDR_EN=0: `tx_start` after edge N+1.
- Inter-byte: next `tx_start` no earlier than 2 cycles after `tx_busy` falls.
- Simultaneous requests: strict round-robin; a lone requester regains grant each packet.
- Requester dropping `req_valid` mid-packet keeps the grant (no preemption).
- `rst` mid-frame: all outputs 0 immediately, state IDLE; partial packet discarded, requester sees no ready until re-granted.
- IDLE with `tx_busy`=1 (external frame in flight): no grant until it clears.

## Test plan
- Single packet, requester 1, bytes 0x00,0xFF(last), HDR_EN=1 -> `uart_rx` receives 0xA1,0x00,0xFF; one `pkt_done`; `grant_valid` low after.
- All 4 requesters valid with 1-byte packets 0x10,0x11,0x12,0x13 -> headers in order 0xA0,0xA1,0xA2,0xA3 after reset; second round starts at 0xA0.
- MAX_LEN=3, requester 2 sends 5 bytes 0x01..0x05 last on 0x05 -> 0xA2,0x01,0x02,0x03, `pkt_trunc`; then 0xA2,0x04,0x05, `pkt_done`.
- Requester 0 stalls 50 cycles between payload bytes while requester 3 valid -> requester 3 never granted until requester 0's last byte; `req_ready[3]` stays 0.
- Assert `rst` during ACK of second payload byte -> all outputs 0 same cycle; after release, a new request produces a fresh header.
- Check per byte: exactly one `tx_start` pulse, never while `tx_busy`=1, `req_ready` one-hot or zero.
